// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Brief    : RV32I instruction decode feeding the ID/EX pipeline register.
// Revision : 1.0
// ============================================================================
module decode_stage #(
    parameter logic [31:0] RESET_PC       = 32'hFFFF_FFFC,
    parameter bit          ZERO_IS_BUBBLE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] ir_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        ready_o,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [4:0]  rd_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [31:0] imm_o,
    output logic [2:0]  funct3_o,
    output logic [3:0]  alu_op_o,
    output logic        alu_src_imm_o,
    output logic        alu_src_pc_o,
    output logic        reg_we_o,
    output logic        mem_re_o,
    output logic        mem_we_o,
    output logic        branch_o,
    output logic        jal_o,
    output logic        jalr_o,
    output logic        illegal_o
);

    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_MISC   = 7'b0001111;
    localparam logic [6:0] c_OPC_SYSTEM = 7'b1110011;

    localparam logic [3:0] c_ALU_ADD   = 4'd0;
    localparam logic [3:0] c_ALU_SUB   = 4'd1;
    localparam logic [3:0] c_ALU_SLL   = 4'd2;
    localparam logic [3:0] c_ALU_SLT   = 4'd3;
    localparam logic [3:0] c_ALU_SLTU  = 4'd4;
    localparam logic [3:0] c_ALU_XOR   = 4'd5;
    localparam logic [3:0] c_ALU_SRL   = 4'd6;
    localparam logic [3:0] c_ALU_SRA   = 4'd7;
    localparam logic [3:0] c_ALU_OR    = 4'd8;
    localparam logic [3:0] c_ALU_AND   = 4'd9;
    localparam logic [3:0] c_ALU_PASSB = 4'd10;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [4:0]  w_rd;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [3:0]  w_alu_f3;
    logic [31:0] w_imm;
    logic [3:0]  w_alu_op;
    logic        w_src_imm, w_src_pc, w_illegal, w_bubble;
    logic        w_reg_we, w_mem_re, w_mem_we, w_branch, w_jal, w_jalr;
    logic [6:0]  w_ctrl;

    logic        r_valid;
    logic [31:0] r_pc;
    logic [4:0]  r_rd, r_rs1, r_rs2;
    logic [31:0] r_imm;
    logic [2:0]  r_funct3;
    logic [3:0]  r_alu_op;
    logic        r_src_imm, r_src_pc;
    logic [6:0]  r_ctrl;   // {reg_we, mem_re, mem_we, branch, jal, jalr, illegal}

    assign w_opcode = ir_i[6:0];
    assign w_funct3 = ir_i[14:12];
    assign w_funct7 = ir_i[31:25];
    assign w_rd     = ir_i[11:7];

    assign w_imm_i = {{20{ir_i[31]}}, ir_i[31:20]};
    assign w_imm_s = {{20{ir_i[31]}}, ir_i[31:25], ir_i[11:7]};
    assign w_imm_b = {{19{ir_i[31]}}, ir_i[31], ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0};
    assign w_imm_u = {ir_i[31:12], 12'b0};
    assign w_imm_j = {{11{ir_i[31]}}, ir_i[31], ir_i[19:12], ir_i[20], ir_i[30:21], 1'b0};

    assign w_bubble = ~valid_i | (ZERO_IS_BUBBLE && (ir_i == 32'd0));

    // Register/immediate ALU op by funct3; ir[30] selects the arithmetic shift.
    always_comb begin
        w_alu_f3 = c_ALU_ADD;
        case (w_funct3)
            3'd1:    w_alu_f3 = c_ALU_SLL;
            3'd2:    w_alu_f3 = c_ALU_SLT;
            3'd3:    w_alu_f3 = c_ALU_SLTU;
            3'd4:    w_alu_f3 = c_ALU_XOR;
            3'd5:    w_alu_f3 = ir_i[30] ? c_ALU_SRA : c_ALU_SRL;
            3'd6:    w_alu_f3 = c_ALU_OR;
            3'd7:    w_alu_f3 = c_ALU_AND;
            default: w_alu_f3 = c_ALU_ADD;
        endcase
    end

    always_comb begin
        w_imm     = '0;
        w_alu_op  = c_ALU_ADD;
        w_src_imm = 1'b0;
        w_src_pc  = 1'b0;
        w_reg_we  = 1'b0;
        w_mem_re  = 1'b0;
        w_mem_we  = 1'b0;
        w_branch  = 1'b0;
        w_jal     = 1'b0;
        w_jalr    = 1'b0;
        w_illegal = 1'b0;
        case (w_opcode)
            c_OPC_OP: begin
                w_reg_we  = 1'b1;
                w_alu_op  = (w_funct3 == 3'd0 && ir_i[30]) ? c_ALU_SUB : w_alu_f3;
                w_illegal = !((w_funct7 == 7'h00) ||
                              (w_funct7 == 7'h20 && (w_funct3 == 3'd0 || w_funct3 == 3'd5)));
            end
            c_OPC_OPIMM: begin
                w_reg_we  = 1'b1;
                w_src_imm = 1'b1;
                w_imm     = w_imm_i;
                w_alu_op  = w_alu_f3;
                w_illegal = ((w_funct3 == 3'd1) && (w_funct7 != 7'h00)) ||
                            ((w_funct3 == 3'd5) && (w_funct7 != 7'h00) && (w_funct7 != 7'h20));
            end
            c_OPC_LOAD: begin
                w_reg_we  = 1'b1;
                w_mem_re  = 1'b1;
                w_src_imm = 1'b1;
                w_imm     = w_imm_i;
                w_illegal = (w_funct3 == 3'd3) || (w_funct3 == 3'd6) || (w_funct3 == 3'd7);
            end
            c_OPC_STORE: begin
                w_mem_we  = 1'b1;
                w_src_imm = 1'b1;
                w_imm     = w_imm_s;
                w_illegal = (w_funct3 > 3'd2);
            end
            c_OPC_BRANCH: begin
                w_branch  = 1'b1;
                w_alu_op  = c_ALU_SUB;
                w_imm     = w_imm_b;
                w_illegal = (w_funct3 == 3'd2) || (w_funct3 == 3'd3);
            end
            c_OPC_JAL: begin
                w_jal     = 1'b1;
                w_reg_we  = 1'b1;
                w_src_pc  = 1'b1;
                w_src_imm = 1'b1;
                w_imm     = w_imm_j;
            end
            c_OPC_JALR: begin
                w_jalr    = 1'b1;
                w_reg_we  = 1'b1;
                w_src_imm = 1'b1;
                w_imm     = w_imm_i;
                w_illegal = (w_funct3 != 3'd0);
            end
            c_OPC_LUI: begin
                w_reg_we  = 1'b1;
                w_src_imm = 1'b1;
                w_alu_op  = c_ALU_PASSB;
                w_imm     = w_imm_u;
            end
            c_OPC_AUIPC: begin
                w_reg_we  = 1'b1;
                w_src_pc  = 1'b1;
                w_src_imm = 1'b1;
                w_imm     = w_imm_u;
            end
            c_OPC_MISC, c_OPC_SYSTEM: begin
                w_illegal = 1'b0;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // Illegal encodings keep valid set but must not touch architectural state.
    assign w_ctrl = {w_reg_we & ~w_illegal & (w_rd != 5'd0),
                     w_mem_re & ~w_illegal, w_mem_we & ~w_illegal,
                     w_branch & ~w_illegal, w_jal & ~w_illegal,
                     w_jalr & ~w_illegal, w_illegal};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_pc      <= RESET_PC;
            r_rd      <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_imm     <= '0;
            r_funct3  <= '0;
            r_alu_op  <= '0;
            r_src_imm <= 1'b0;
            r_src_pc  <= 1'b0;
            r_ctrl    <= '0;
        end else if (flush_i || (!stall_i && w_bubble)) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (!stall_i) begin
            r_valid   <= 1'b1;
            r_pc      <= pc_i;
            r_rd      <= w_rd;
            r_rs1     <= ir_i[19:15];
            r_rs2     <= ir_i[24:20];
            r_imm     <= w_imm;
            r_funct3  <= w_funct3;
            r_alu_op  <= w_alu_op;
            r_src_imm <= w_src_imm;
            r_src_pc  <= w_src_pc;
            r_ctrl    <= w_ctrl;
        end
    end

    assign ready_o       = ~stall_i;
    assign valid_o       = r_valid;
    assign pc_o          = r_pc;
    assign rd_o          = r_rd;
    assign rs1_o         = r_rs1;
    assign rs2_o         = r_rs2;
    assign imm_o         = r_imm;
    assign funct3_o      = r_funct3;
    assign alu_op_o      = r_alu_op;
    assign alu_src_imm_o = r_src_imm;
    assign alu_src_pc_o  = r_src_pc;
    assign {reg_we_o, mem_re_o, mem_we_o, branch_o, jal_o, jalr_o, illegal_o} = r_ctrl;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage
// Brief    : Vector table, hand sequences and random traffic vs. a decode model.
// Revision : 1.0
// ============================================================================
module tb_decode_stage;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic [3:0]  alu;
        logic        simm, spc, we, re, mwe, br, jal, jalr, ill;
    } dec_t;

    typedef struct {
        logic        r, v, s, f;
        logic [31:0] pc, ir;
        logic        e_valid;
        logic [31:0] e_pc, e_imm;
        logic [3:0]  e_alu;
        logic [6:0]  e_ctrl;   // {we, re, mwe, br, jal, jalr, ill}
        int          lvl;      // 0 control only, 1 + pc, 2 + pc/imm/alu
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1, valid_i = 1'b0, stall_i = 1'b0, flush_i = 1'b0;
    logic [31:0] pc_i = '0, ir_i = '0;
    logic        ready_o, valid_o, alu_src_imm_o, alu_src_pc_o, reg_we_o, mem_re_o;
    logic        mem_we_o, branch_o, jal_o, jalr_o, illegal_o;
    logic [31:0] pc_o, imm_o;
    logic [4:0]  rd_o, rs1_o, rs2_o;
    logic [2:0]  funct3_o;
    logic [3:0]  alu_op_o;

    int   n_checks = 0;
    int   n_errors = 0;
    dec_t exp_s, msk_s, dut_v;

    decode_stage #(.RESET_PC(32'hFFFF_FFFC), .ZERO_IS_BUBBLE(1'b1)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .pc_i(pc_i), .ir_i(ir_i),
        .stall_i(stall_i), .flush_i(flush_i), .ready_o(ready_o), .valid_o(valid_o),
        .pc_o(pc_o), .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .imm_o(imm_o),
        .funct3_o(funct3_o), .alu_op_o(alu_op_o), .alu_src_imm_o(alu_src_imm_o),
        .alu_src_pc_o(alu_src_pc_o), .reg_we_o(reg_we_o), .mem_re_o(mem_re_o),
        .mem_we_o(mem_we_o), .branch_o(branch_o), .jal_o(jal_o), .jalr_o(jalr_o),
        .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    assign dut_v = {valid_o, pc_o, rd_o, rs1_o, rs2_o, imm_o, funct3_o, alu_op_o,
                    alu_src_imm_o, alu_src_pc_o, reg_we_o, mem_re_o, mem_we_o,
                    branch_o, jal_o, jalr_o, illegal_o};

    function automatic dec_t ctrl_mask();
        dec_t m = '0;
        m.valid = 1'b1; m.we = 1'b1; m.re = 1'b1; m.mwe = 1'b1;
        m.br = 1'b1; m.jal = 1'b1; m.jalr = 1'b1; m.ill = 1'b1;
        return m;
    endfunction

    function automatic dec_t ill_mask();
        dec_t m = ctrl_mask();
        m.pc = '1; m.rd = '1; m.rs1 = '1; m.rs2 = '1; m.f3 = '1;
        return m;
    endfunction

    // Reference decode written from the ISA rules, immediates built arithmetically.
    function automatic dec_t ref_decode(input logic [31:0] pc, input logic [31:0] ir);
        dec_t               d;
        logic signed [31:0] s;
        logic [31:0]        sx, t25, imm_i, imm_s, imm_b, imm_u, imm_j;
        logic [6:0]         f7;
        logic [3:0]         base [8];
        base  = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        s     = ir;
        sx    = s >>> 31;
        t25   = s >>> 25;
        imm_i = s >>> 20;
        imm_s = (t25 << 5) | 32'(ir[11:7]);
        imm_b = (sx << 12) | (32'(ir[7]) << 11) | (32'(ir[30:25]) << 5) | (32'(ir[11:8]) << 1);
        imm_u = ir & 32'hFFFF_F000;
        imm_j = (sx << 20) | (32'(ir[19:12]) << 12) | (32'(ir[20]) << 11) | (32'(ir[30:21]) << 1);
        f7    = ir[31:25];
        d = '0;
        d.valid = 1'b1; d.pc = pc; d.rd = ir[11:7]; d.rs1 = ir[19:15];
        d.rs2 = ir[24:20]; d.f3 = ir[14:12];
        case (ir[6:0])
            7'h33: begin
                d.we = 1'b1; d.alu = base[d.f3];
                if (f7 == 7'h20 && d.f3 == 3'd0) d.alu = 4'd1;
                if (f7 == 7'h20 && d.f3 == 3'd5) d.alu = 4'd7;
                d.ill = !(f7 == 7'h00 || (f7 == 7'h20 && (d.f3 == 3'd0 || d.f3 == 3'd5)));
            end
            7'h13: begin
                d.we = 1'b1; d.simm = 1'b1; d.imm = imm_i; d.alu = base[d.f3];
                if (d.f3 == 3'd5 && f7 == 7'h20) d.alu = 4'd7;
                d.ill = (d.f3 == 3'd1 && f7 != 7'h00) ||
                        (d.f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
            end
            7'h03: begin
                d.we = 1'b1; d.re = 1'b1; d.simm = 1'b1; d.imm = imm_i;
                d.ill = !(d.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
            end
            7'h23: begin d.mwe = 1'b1; d.simm = 1'b1; d.imm = imm_s; d.ill = (d.f3 > 3'd2); end
            7'h63: begin d.br = 1'b1; d.alu = 4'd1; d.imm = imm_b; d.ill = (d.f3 inside {3'd2, 3'd3}); end
            7'h6F: begin d.jal = 1'b1; d.we = 1'b1; d.spc = 1'b1; d.simm = 1'b1; d.imm = imm_j; end
            7'h67: begin d.jalr = 1'b1; d.we = 1'b1; d.simm = 1'b1; d.imm = imm_i; d.ill = (d.f3 != 3'd0); end
            7'h37: begin d.we = 1'b1; d.simm = 1'b1; d.alu = 4'd10; d.imm = imm_u; end
            7'h17: begin d.we = 1'b1; d.spc = 1'b1; d.simm = 1'b1; d.imm = imm_u; end
            7'h0F, 7'h73: d.ill = 1'b0;
            default: d.ill = 1'b1;
        endcase
        if (d.ill) begin
            d.we = 1'b0; d.re = 1'b0; d.mwe = 1'b0; d.br = 1'b0; d.jal = 1'b0; d.jalr = 1'b0;
        end
        if (d.rd == 5'd0) d.we = 1'b0;
        return d;
    endfunction

    task automatic model_step(input logic r, v, s, f, input logic [31:0] pc, ir);
        if (r) begin
            exp_s = '0; exp_s.pc = 32'hFFFF_FFFC; msk_s = '1;
        end else if (f || (!s && (!v || ir == 32'd0))) begin
            exp_s.valid = 1'b0; exp_s.we = 1'b0; exp_s.re = 1'b0; exp_s.mwe = 1'b0;
            exp_s.br = 1'b0; exp_s.jal = 1'b0; exp_s.jalr = 1'b0; exp_s.ill = 1'b0;
            msk_s = ctrl_mask();
        end else if (!s) begin
            exp_s = ref_decode(pc, ir);
            msk_s = exp_s.ill ? ill_mask() : '1;
        end
    endtask

    task automatic check(input string name, input dec_t act, input dec_t expv, input dec_t m);
        n_checks++;
        if (((act ^ expv) & m) != '0) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h care=%h", name, act, expv, m);
        end
    endtask

    task automatic step(input logic r, v, s, f, input logic [31:0] pc, ir);
        dec_t ra, re, rm;
        rst = r; valid_i = v; stall_i = s; flush_i = f; pc_i = pc; ir_i = ir;
        #1;
        ra = '0; re = '0; rm = '0;
        ra.valid = ready_o; re.valid = ~s; rm.valid = 1'b1;
        check("ready", ra, re, rm);
        model_step(r, v, s, f, pc, ir);
        @(posedge clk);
        #1;
        check("model", dut_v, exp_s, msk_s);
    endtask

    function automatic vec_t mk(input logic r, v, s, f, input logic [31:0] pc, ir,
                                input logic ev, input logic [31:0] epc, eimm,
                                input logic [3:0] ealu, input logic [6:0] ectrl, input int lvl);
        vec_t t;
        t.r = r; t.v = v; t.s = s; t.f = f; t.pc = pc; t.ir = ir; t.e_valid = ev;
        t.e_pc = epc; t.e_imm = eimm; t.e_alu = ealu; t.e_ctrl = ectrl; t.lvl = lvl;
        return t;
    endfunction

    function automatic logic [31:0] rand_ir();
        logic [6:0]  ops [11];
        logic [31:0] r;
        int          k;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h0F, 7'h73};
        r = $urandom;
        k = $urandom_range(0, 12);
        if (k < 11) r[6:0] = ops[k];
        k = $urandom_range(0, 3);
        if (k == 0) r[31:25] = 7'h00;
        if (k == 1) r[31:25] = 7'h20;
        if ($urandom_range(0, 40) == 0) r = 32'd0;
        return r;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[$];
        dec_t e, m;
        // r v s f  pc  ir             valid pc          imm           alu  ctrl      lvl
        tbl.push_back(mk(1,0,0,0, 32'h0,   32'h0,        0, 32'hFFFF_FFFC, 32'h0,         4'd0, 7'b0000000, 2));
        tbl.push_back(mk(1,0,0,0, 32'h0,   32'h0,        0, 32'hFFFF_FFFC, 32'h0,         4'd0, 7'b0000000, 2));
        tbl.push_back(mk(0,1,0,0, 32'h0,   32'h0,        0, 32'h0,         32'h0,         4'd0, 7'b0000000, 0));
        tbl.push_back(mk(0,1,0,0, 32'h100, 32'hFFF10093, 1, 32'h100,       32'hFFFF_FFFF, 4'd0, 7'b1000000, 2));
        tbl.push_back(mk(0,1,0,0, 32'h104, 32'h00552423, 1, 32'h104,       32'h8,         4'd0, 7'b0010000, 2));
        tbl.push_back(mk(0,1,0,0, 32'h108, 32'hFE000EE3, 1, 32'h108,       32'hFFFF_FFFC, 4'd1, 7'b0001000, 2));
        tbl.push_back(mk(0,1,0,0, 32'h10C, 32'h02208033, 1, 32'h10C,       32'h0,         4'd0, 7'b0000001, 1));
        tbl.push_back(mk(0,1,0,0, 32'h110, 32'h00000013, 1, 32'h110,       32'h0,         4'd0, 7'b0000000, 2));
        tbl.push_back(mk(0,1,0,0, 32'h200, 32'hFFF10093, 1, 32'h200,       32'hFFFF_FFFF, 4'd0, 7'b1000000, 2));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0,1,1,0, 32'h204, 32'h00552423, 1, 32'h200,   32'hFFFF_FFFF, 4'd0, 7'b1000000, 2));
        tbl.push_back(mk(0,1,1,1, 32'h204, 32'h00552423, 0, 32'h0,         32'h0,         4'd0, 7'b0000000, 0));
        tbl.push_back(mk(0,1,0,0, 32'h204, 32'h00552423, 1, 32'h204,       32'h8,         4'd0, 7'b0010000, 2));
        tbl.push_back(mk(0,1,0,0, 32'h300, 32'hFFF10093, 1, 32'h300,       32'hFFFF_FFFF, 4'd0, 7'b1000000, 2));
        tbl.push_back(mk(0,1,1,0, 32'h304, 32'h00552423, 1, 32'h300,       32'hFFFF_FFFF, 4'd0, 7'b1000000, 2));
        tbl.push_back(mk(1,1,1,0, 32'h304, 32'h00552423, 0, 32'hFFFF_FFFC, 32'h0,         4'd0, 7'b0000000, 2));

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].f, tbl[i].pc, tbl[i].ir);
            e = '0; m = ctrl_mask();
            e.valid = tbl[i].e_valid;
            {e.we, e.re, e.mwe, e.br, e.jal, e.jalr, e.ill} = tbl[i].e_ctrl;
            e.pc = tbl[i].e_pc; e.imm = tbl[i].e_imm; e.alu = tbl[i].e_alu;
            if (tbl[i].lvl >= 1) m.pc = '1;
            if (tbl[i].lvl >= 2) begin m.imm = '1; m.alu = '1; end
            check($sformatf("vector%0d", i), dut_v, e, m);
        end

        // JAL held across a stall, then flush alone, then an invalid slot.
        step(0, 1, 0, 0, 32'h400, 32'h008000EF);
        step(0, 1, 1, 0, 32'h404, 32'h12345678);
        step(0, 0, 1, 0, 32'h408, 32'h00000013);
        e = '0; m = '0;
        e.valid = 1'b1; e.we = 1'b1; e.jal = 1'b1; e.spc = 1'b1; e.imm = 32'h8; e.pc = 32'h400; e.rd = 5'd1;
        m.valid = 1'b1; m.we = 1'b1; m.jal = 1'b1; m.spc = 1'b1; m.imm = '1; m.pc = '1; m.rd = '1;
        check("jal_held", dut_v, e, m);
        step(0, 1, 0, 1, 32'h40C, 32'h00552423);
        step(0, 0, 0, 0, 32'h410, 32'h00552423);
        step(0, 1, 0, 0, 32'h414, 32'h000000B7);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 90,
                 $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 5,
                 $urandom & 32'hFFFF_FFFC, rand_ir());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
